// File: rtl/main.sv
// main -- drift-tube hit acquisition with a trigger-opened time window and
// an event FIFO read out through a slow, asynchronously sampled read strobe.
//
// Optional feature: define HEADER_WORD_EN to prefix every accepted trigger
// with a header word {1'b1, event_number[14:0]}.
//
// Hit word format: {1'b0, wire[4:0], time[9:0]}.
// Wire numbering: TUBE3A -> 0..7, TUBE3B -> 8..15, TUBE4A -> 16..23,
// TUBE4B -> 24..31.
module main #(
  parameter int unsigned WINDOW_CYCLES = 400,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        SCIN_COIN,
  input  logic [7:0]  TUBE3A,
  input  logic [7:0]  TUBE3B,
  input  logic [7:0]  TUBE4A,
  input  logic [7:0]  TUBE4B,
  input  logic        RD_CLK,
  input  logic        RD_EN,
  output logic [15:0] OTUBE,
  output logic        RD_EMPTY,
  output logic        RD_VALID,
  output logic        overflowLight
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [9:0]  LAST_CNT = 10'(WINDOW_CYCLES - 1);

  // Positions of the non-wire inputs inside the synchronizer vector.
  localparam int unsigned TRIG_BIT  = 32;
  localparam int unsigned RDCLK_BIT = 33;
  localparam int unsigned RDEN_BIT  = 34;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WINDOW,
    ST_FLUSH
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronization and edge detection
  // ---------------------------------------------------------------------
  logic [34:0] async_in;
  logic [34:0] meta_q;
  logic [34:0] sync_q;
  logic [33:0] prev_q;

  logic [31:0] wire_edge;
  logic        trig_edge;
  logic        rd_edge;
  logic        rd_en_s;

  assign async_in = {RD_EN, RD_CLK, SCIN_COIN, TUBE4B, TUBE4A, TUBE3B, TUBE3A};

  // Two-flop synchronizers plus a delayed copy for rising-edge detection;
  // every input sees the same latency so trigger/wire timing is preserved.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q[33:0];
    end
  end

  assign wire_edge = sync_q[31:0] & ~prev_q[31:0];
  assign trig_edge = sync_q[TRIG_BIT] & ~prev_q[TRIG_BIT];
  assign rd_edge   = sync_q[RDCLK_BIT] & ~prev_q[RDCLK_BIT];
  assign rd_en_s   = sync_q[RDEN_BIT];

  // ---------------------------------------------------------------------
  // Acquisition window
  // ---------------------------------------------------------------------
  state_t      state_q;
  logic [9:0]  cnt_q;
  logic [31:0] pending_q;
  logic [31:0] pending_d;

  logic        hit_found;
  logic [4:0]  hit_idx;
  logic        hit_take;
  logic        wr_req;
  logic [15:0] wr_word;

`ifdef HEADER_WORD_EN
  logic [14:0] evt_q;
  logic        hdr_req;

  assign hdr_req = (state_q == ST_IDLE) && trig_edge;
`endif

  // Lowest-index pending wire is the one written this cycle.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!hit_found && pending_q[i]) begin
        hit_found = 1'b1;
        hit_idx   = 5'(i);
      end
    end
  end

  // Select the word offered to the FIFO; a header pre-empts any hit.
  always_comb begin
    wr_req   = 1'b0;
    wr_word  = '0;
    hit_take = 1'b0;
    if (hit_found) begin
      wr_req   = 1'b1;
      hit_take = 1'b1;
      wr_word  = {1'b0, hit_idx, cnt_q};
    end
`ifdef HEADER_WORD_EN
    if (hdr_req) begin
      wr_req   = 1'b1;
      hit_take = 1'b0;
      wr_word  = {1'b1, evt_q};
    end
`endif
  end

  // Pending set: clear the wire just written, add new edges while in window.
  always_comb begin
    pending_d = pending_q;
    if (hit_take) begin
      pending_d[hit_idx] = 1'b0;
    end
    if (state_q == ST_WINDOW) begin
      pending_d = pending_d | wire_edge;
    end
  end

  // Window sequencing; after the window the counter parks at 1023 while
  // leftover pending hits drain, so late hits carry the saturated time.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
`ifdef HEADER_WORD_EN
      evt_q     <= '0;
`endif
    end else begin
      pending_q <= pending_d;
      case (state_q)
        ST_IDLE: begin
          if (trig_edge) begin
            state_q <= ST_WINDOW;
            cnt_q   <= '0;
`ifdef HEADER_WORD_EN
            evt_q   <= evt_q + 15'd1;
`endif
          end
        end
        ST_WINDOW: begin
          if (cnt_q == LAST_CNT) begin
            if (pending_d != '0) begin
              state_q <= ST_FLUSH;
              cnt_q   <= '1;
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        ST_FLUSH: begin
          if (pending_d == '0) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO and read port
  // ---------------------------------------------------------------------
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [AW:0] wr_ptr_d;
  logic [AW:0] rd_ptr_d;
  logic        fifo_nonempty;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic        empty_q;
  logic        ovf_q;
  logic [15:0] otube_q;
  logic        valid_q;

  // A pop in the same cycle frees the slot, so a write into a full FIFO
  // still succeeds then.
  always_comb begin
    fifo_nonempty = (wr_ptr_q != rd_ptr_q);
    fifo_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop           = rd_edge && rd_en_s && fifo_nonempty;
    push          = wr_req && (!fifo_full || pop);
    wr_ptr_d      = push ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
    rd_ptr_d      = pop  ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
  end

  // Storage array; contents are meaningless until written.
  always_ff @(posedge clk100) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end
  end

  // Pointers, status flags and the registered read word.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      otube_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= (wr_ptr_d == rd_ptr_d);
      if (wr_req && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end
      if (rd_edge && rd_en_s) begin
        if (fifo_nonempty) begin
          otube_q <= mem_q[rd_ptr_q[AW-1:0]];
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign OTUBE         = otube_q;
  assign RD_EMPTY      = empty_q;
  assign RD_VALID      = valid_q;
  assign overflowLight = ovf_q;

endmodule

// File: tb/tb_main.sv
// Bench for main: directed trigger/wire scenarios, an event-level model of
// the expected FIFO contents, and literal pins on the key hit words.
module tb_main;

  localparam int W     = 400;
  localparam int DEPTH = 16;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        SCIN_COIN;
  logic [31:0] wires;
  logic        RD_CLK;
  logic        RD_EN;
  logic [15:0] OTUBE;
  logic        RD_EMPTY;
  logic        RD_VALID;
  logic        overflowLight;

  main #(.WINDOW_CYCLES(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk100       (clk100),
    .rst          (rst),
    .SCIN_COIN    (SCIN_COIN),
    .TUBE3A       (wires[7:0]),
    .TUBE3B       (wires[15:8]),
    .TUBE4A       (wires[23:16]),
    .TUBE4B       (wires[31:24]),
    .RD_CLK       (RD_CLK),
    .RD_EN        (RD_EN),
    .OTUBE        (OTUBE),
    .RD_EMPTY     (RD_EMPTY),
    .RD_VALID     (RD_VALID),
    .overflowLight(overflowLight)
  );

  always #5 clk100 = ~clk100;

  // Model state
  logic [15:0] mq[$];
  logic [15:0] pin_q[$];
  logic [15:0] exp_otube;
  bit          exp_valid;
  bit          exp_ovf;
  int          evt_no;

  // Scenario description: wire index, rise offset from trigger, pulse length
  int ev_w[$];
  int ev_d[$];
  int ev_len[$];

  int          errors = 0;
  int          checks = 0;
  bit          chk_req = 1'b0;
  bit          lit_on = 1'b0;
  logic [15:0] lit;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks settled outputs whenever a check is requested.
  initial begin
    forever begin
      @(negedge clk100);
      if (chk_req) begin
        cmp("rd_empty", {15'b0, RD_EMPTY}, {15'b0, (mq.size() == 0)});
        cmp("rd_valid", {15'b0, RD_VALID}, {15'b0, exp_valid});
        cmp("otube", OTUBE, exp_otube);
        cmp("overflow", {15'b0, overflowLight}, {15'b0, exp_ovf});
        if (lit_on) begin
          cmp("otube_pin", OTUBE, lit);
          lit_on = 1'b0;
        end
        chk_req = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic request_check();
    chk_req = 1'b1;
    for (int i = 0; i < 10 && chk_req; i++) @(posedge clk100);
    if (chk_req) begin
      errors++;
      checks++;
      $display("FAIL check_handshake: got no response expected response");
      chk_req = 1'b0;
    end
  endtask

  task automatic model_push(input logic [15:0] w);
    if (mq.size() < DEPTH) mq.push_back(w);
    else exp_ovf = 1'b1;
  endtask

  task automatic model_reset();
    mq.delete();
    pin_q.delete();
    exp_otube = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    evt_no    = 0;
  endtask

  // Expected words for one event: hits accepted when 1 <= offset <= W,
  // drained one per cycle lowest wire first, time = cycles since trigger,
  // saturating to 1023 once past the window.
  task automatic model_event();
    bit [31:0] pend;
    int        idx;
    int        t;
    pend = '0;
`ifdef HEADER_WORD_EN
    model_push(16'h8000 | 16'(evt_no));
    pin_q.push_front(16'h8000 | 16'(evt_no));
`endif
    evt_no++;
    for (int k = 2; k <= W + 40; k++) begin
      for (int j = 0; j < ev_w.size(); j++)
        if (ev_d[j] == k - 1 && ev_d[j] >= 1 && ev_d[j] <= W) pend[ev_w[j]] = 1'b1;
      if (pend != '0) begin
        idx = 0;
        for (int i = 31; i >= 0; i--) if (pend[i]) idx = i;
        pend[idx] = 1'b0;
        t = (k - 1 < W) ? (k - 1) : 1023;
        model_push({1'b0, 5'(idx), 10'(t)});
      end
    end
  endtask

  task automatic clear_ev();
    ev_w.delete();
    ev_d.delete();
    ev_len.delete();
    pin_q.delete();
  endtask

  task automatic add_ev(input int w, input int d, input int len);
    ev_w.push_back(w);
    ev_d.push_back(d);
    ev_len.push_back(len);
  endtask

  // Trigger rises at offset 0; optional retrigger at offset 50; optional
  // reset at offset rst_at (aborts the event).
  task automatic run_event(input bit retrig, input int rst_at);
    for (int c = -5; c <= W + 20; c++) begin
      @(negedge clk100);
      if (rst_at >= 0 && c == rst_at) begin
        wires     = '0;
        SCIN_COIN = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk100);
        rst = 1'b0;
        break;
      end
      SCIN_COIN = (c >= 0 && c < 4) || (retrig && c >= 50 && c < 54);
      wires = '0;
      for (int j = 0; j < ev_w.size(); j++)
        if (c >= ev_d[j] && c < ev_d[j] + ev_len[j]) wires[ev_w[j]] = 1'b1;
    end
    wires     = '0;
    SCIN_COIN = 1'b0;
    if (rst_at >= 0) begin
      model_reset();
      lit    = 16'h0000;
      lit_on = 1'b1;
    end else begin
      model_event();
    end
    repeat (5) @(negedge clk100);
    request_check();
  endtask

  // One 1 MHz RD_CLK period, then settle and compare.
  task automatic rd_pulse();
    @(negedge clk100);
    RD_CLK = 1'b1;
    repeat (50) @(negedge clk100);
    RD_CLK = 1'b0;
    repeat (50) @(negedge clk100);
    if (RD_EN) begin
      if (mq.size() > 0) begin
        exp_otube = mq.pop_front();
        exp_valid = 1'b1;
        if (pin_q.size() > 0) begin
          lit    = pin_q.pop_front();
          lit_on = 1'b1;
        end
      end else begin
        exp_valid = 1'b0;
      end
    end
    request_check();
  endtask

  task automatic read_all();
    for (int n = 0; n < DEPTH + 1 && mq.size() > 0; n++) rd_pulse();
    rd_pulse();
    pin_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk100);
    rst = 1'b1;
    repeat (3) @(negedge clk100);
    rst = 1'b0;
    model_reset();
    lit    = 16'h0000;
    lit_on = 1'b1;
    repeat (3) @(negedge clk100);
    request_check();
  endtask

  initial begin
    rst       = 1'b1;
    SCIN_COIN = 1'b0;
    wires     = '0;
    RD_CLK    = 1'b0;
    RD_EN     = 1'b0;
    model_reset();
    repeat (5) @(negedge clk100);
    rst = 1'b0;
    lit    = 16'h0000;
    lit_on = 1'b1;
    repeat (3) @(negedge clk100);
    request_check();

    // Read on an empty FIFO
    RD_EN = 1'b1;
    rd_pulse();

    // Wire pulse ahead of the trigger is not a hit
    clear_ev();
    add_ev(4, -3, 3);
    run_event(1'b0, -1);
    read_all();

    // Four hits at 13, 16, 20, 22 cycles after trigger
    clear_ev();
    add_ev(4, 13, 3);
    add_ev(11, 16, 3);
    add_ev(17, 20, 3);
    add_ev(24, 22, 3);
    pin_q.push_back(16'h100D);
    pin_q.push_back(16'h2C10);
    pin_q.push_back(16'h4414);
    pin_q.push_back(16'h6016);
    run_event(1'b0, -1);
    read_all();

    // Simultaneous wires 5 and 2 at time 7; a read with RD_EN low first
    clear_ev();
    add_ev(5, 7, 3);
    add_ev(2, 7, 3);
    pin_q.push_back(16'h0807);
    pin_q.push_back(16'h1408);
    run_event(1'b0, -1);
    RD_EN = 1'b0;
    rd_pulse();
    RD_EN = 1'b1;
    read_all();

    // Retrigger at 50 ignored; hit at 60 keeps window-relative time
    clear_ev();
    add_ev(6, 60, 3);
    pin_q.push_back(16'h183C);
    run_event(1'b1, -1);
    read_all();

    // Window edges: held-high level, last window cycle, saturated flush, outside
    clear_ev();
    add_ev(3, 1, 100);
    add_ev(7, W - 1, 3);
    add_ev(8, W, 3);
    add_ev(9, W + 1, 3);
    pin_q.push_back(16'h0C01);
    pin_q.push_back(16'h1D8F);
    pin_q.push_back(16'h23FF);
    run_event(1'b0, -1);
    read_all();

    // Overflow: 17 hits in one cycle, no reads
    clear_ev();
    for (int i = 0; i < DEPTH + 1; i++) add_ev(i, 10, 3);
    run_event(1'b0, -1);
    read_all();
    do_reset();

    // Reset in the middle of a window discards stored hits
    clear_ev();
    add_ev(1, 5, 3);
    run_event(1'b0, 15);

    // Normal acquisition after reset
    clear_ev();
    add_ev(31, 2, 3);
    pin_q.push_back(16'h7C02);
    run_event(1'b0, -1);
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
